// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sccb_pkg
// Description : Shared types and constants for the SCCB camera responder.
//               Holds the FSM state encoding, the default device address,
//               the read-only sub-addresses and the ID-byte values.
// Revision    : 1.0 - initial release
// ============================================================================
package sccb_pkg;

    // Protocol FSM states, explicitly 4 bits wide
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } sccb_state_e;

    localparam logic [6:0] c_dev_id_default = 7'h21;
    localparam logic [7:0] c_pid_addr       = 8'h0A;
    localparam logic [7:0] c_ver_addr       = 8'h0B;
    localparam logic [7:0] c_id_write       = 8'h42;
    localparam logic [7:0] c_id_read        = 8'h43;

    // True for the sub-addresses backed by fixed identification values
    function automatic logic is_ro_addr(input logic [7:0] addr);
        return (addr == c_pid_addr) || (addr == c_ver_addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : sccb_line_sync
// Description : Two-flop synchronizers for SCL/SDA plus START, STOP and
//               SCL edge pulses derived from the synchronized levels.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic start_o,
    output logic stop_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;
    logic       w_scl;
    logic       w_sda;

    // Synchronizer chains and one-cycle history; idle bus level is high
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign w_scl = scl_sync_q[1];
    assign w_sda = sda_sync_q[1];

    assign sda_o      = w_sda;
    // SDA transitions only count as bus conditions while SCL is stably high
    assign start_o    = sda_prev_q & ~w_sda & scl_prev_q & w_scl;
    assign stop_o     = ~sda_prev_q & w_sda & scl_prev_q & w_scl;
    assign scl_rise_o = ~scl_prev_q & w_scl;
    assign scl_fall_o = scl_prev_q & ~w_scl;

endmodule
`default_nettype wire

// File: rtl/sccb_cam_responder.sv
`default_nettype none
// ============================================================================
// Module      : sccb_cam_responder
// Description : SCCB target emulating a camera register file (256x8) with
//               read-only PID/VER locations, auto-incrementing sub-address
//               and a combinational debug peek port.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_cam_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID  = c_dev_id_default,
    parameter logic [7:0] PID_VAL = 8'h76,
    parameter logic [7:0] VER_VAL = 8'h73
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic       reg_we_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       busy_o,
    input  logic [7:0] dbg_addr_i,
    output logic [7:0] dbg_data_o
);

    logic        w_sda_s;
    logic        w_start;
    logic        w_stop;
    logic        w_rise;
    logic        w_fall;

    sccb_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        ack_drv_q, ack_drv_d;
    logic        rw_q, rw_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  reg_wdata_q, reg_wdata_d;
    logic        reg_we_q, reg_we_d;
    logic [7:0]  mem_q [0:255];

    logic [7:0]  w_byte;
    logic [7:0]  w_rd_byte;
    logic        w_last_bit;
    logic [2:0]  w_bit_idx;
    logic        w_id_match;
    logic        w_commit;

    sccb_line_sync u_line_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .sda_o      (w_sda_s),
        .start_o    (w_start),
        .stop_o     (w_stop),
        .scl_rise_o (w_rise),
        .scl_fall_o (w_fall)
    );

    // Byte as it stands once the bit sampled on this rising edge is included
    assign w_byte     = {shift_q[6:0], w_sda_s};
    assign w_last_bit = (cnt_q == 4'd7);
    assign w_bit_idx  = 3'd7 - cnt_q[2:0];
    assign w_id_match = (w_byte[7:1] == DEV_ID);
    assign w_rd_byte  = (reg_addr_q == c_pid_addr) ? PID_VAL :
                        (reg_addr_q == c_ver_addr) ? VER_VAL : mem_q[reg_addr_q];
    assign dbg_data_o = (dbg_addr_i == c_pid_addr) ? PID_VAL :
                        (dbg_addr_i == c_ver_addr) ? VER_VAL : mem_q[dbg_addr_i];
    // Bus conditions take priority over bit sampling in the same cycle
    assign w_commit   = ~w_stop & ~w_start & w_rise & (state_q == ST_WDATA)
                        & w_last_bit & ~is_ro_addr(reg_addr_q);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: bytes end on the 8th rising edge, ACK slots end on a fall
    always_comb begin
        state_d = state_q;
        if (w_stop) begin
            state_d = ST_IDLE;
        end else if (w_start) begin
            state_d = ST_ID;
        end else if (w_rise) begin
            case (state_q)
                ST_ID:        if (w_last_bit) state_d = w_id_match ? ST_ID_ACK : ST_IGNORE;
                ST_SUB:       if (w_last_bit) state_d = ST_SUB_ACK;
                ST_WDATA:     if (w_last_bit) state_d = ST_WDATA_ACK;
                ST_RDATA:     if (w_last_bit) state_d = ST_RDATA_ACK;
                ST_RDATA_ACK: state_d = w_sda_s ? ST_IGNORE : ST_RDATA;
                default:      state_d = state_q;
            endcase
        end else if (w_fall && ack_drv_q) begin
            case (state_q)
                ST_ID_ACK:    state_d = rw_q ? ST_RDATA : ST_SUB;
                ST_SUB_ACK:   state_d = ST_WDATA;
                ST_WDATA_ACK: state_d = ST_WDATA;
                default:      state_d = state_q;
            endcase
        end
    end

    // Output/datapath next values; SDA_OE only moves on SCL falls, START or STOP
    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ack_drv_d   = ack_drv_q;
        rw_d        = rw_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = w_commit;
        if (w_stop) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            ack_drv_d = 1'b0;
            cnt_d     = 4'd0;
        end else if (w_start) begin
            sda_oe_d  = 1'b0;
            ack_drv_d = 1'b0;
            cnt_d     = 4'd0;
        end else if (w_rise) begin
            case (state_q)
                ST_ID: begin
                    shift_d = w_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (w_last_bit && w_id_match) begin
                        busy_d = 1'b1;
                        rw_d   = w_byte[0];
                    end
                end
                ST_SUB: begin
                    shift_d = w_byte;
                    cnt_d   = cnt_q + 4'd1;
                end
                ST_WDATA: begin
                    shift_d = w_byte;
                    cnt_d   = cnt_q + 4'd1;
                    if (w_commit) reg_wdata_d = w_byte;
                end
                ST_RDATA: cnt_d = cnt_q + 4'd1;
                ST_RDATA_ACK: begin
                    if (!w_sda_s) begin
                        reg_addr_d = reg_addr_q + 8'd1;
                        cnt_d      = 4'd0;
                    end
                end
                default: ;
            endcase
        end else if (w_fall) begin
            case (state_q)
                ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (!ack_drv_q) begin
                        sda_oe_d  = 1'b1;
                        ack_drv_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        ack_drv_d = 1'b0;
                        cnt_d     = 4'd0;
                        if (state_q == ST_ID_ACK && rw_q) sda_oe_d = ~w_rd_byte[7];
                        if (state_q == ST_SUB_ACK)        reg_addr_d = shift_q;
                        if (state_q == ST_WDATA_ACK)      reg_addr_d = reg_addr_q + 8'd1;
                    end
                end
                ST_RDATA: sda_oe_d = ~w_rd_byte[w_bit_idx];
                default:  sda_oe_d = 1'b0;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            ack_drv_q   <= 1'b0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ack_drv_q   <= ack_drv_d;
            rw_q        <= rw_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
        end
    end

    // Register file; PID/VER slots are never written and read via the mux
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
        end else if (w_commit) begin
            mem_q[reg_addr_q] <= w_byte;
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign reg_we_o    = reg_we_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: doc/sccb_cam_responder.md
SCCB_CAM_RESPONDER -- requirements
Module: sccb_cam_responder

Interface
REQ-001 SHALL have parameter DEV_ID, default 7'h21, the 7-bit device address (write byte 0x42, read byte 0x43).
REQ-002 SHALL have parameter PID_VAL, default 8'h76, the read-only value at sub-address 0x0A.
REQ-003 SHALL have parameter VER_VAL, default 8'h73, the read-only value at sub-address 0x0B.
REQ-004 SHALL have one clock and a synchronous, active-high reset; all other inputs are asynchronous to CLK.
REQ-005 CLK  in  1  system clock, at least 8x the SCL frequency.
REQ-006 RST  in  1  reset, synchronous to CLK, active-high.
REQ-007 SCL  in  1  SCCB clock from the initiator, asynchronous.
REQ-008 SDA_IN  in  1  sensed SDA line level, asynchronous.
REQ-009 SDA_OE  out  1  1 = pull SDA low, 0 = release SDA.
REQ-010 REG_WE  out  1  one-CLK pulse on each committed register write.
REQ-011 REG_ADDR  out  8  sub-address of the current or last access.
REQ-012 REG_WDATA  out  8  data byte of the last committed write.
REQ-013 BUSY  out  1  high from an address-matched ID byte until STOP.
REQ-014 DBG_ADDR  in  8  peek address.
REQ-015 DBG_DATA  out  8  combinational register-file contents at DBG_ADDR.

Function
REQ-016 SCL and SDA_IN SHALL each pass a 2-FF synchronizer; edge detection SHALL use the synchronized values, so the internal latency is 2-3 CLK.
REQ-017 START is a synced SDA fall while synced SCL is high; STOP is a synced SDA rise while synced SCL is high.
REQ-018 Bits SHALL be sampled on the synced SCL rising edge, MSB first.
REQ-019 SDA_OE SHALL change only on the synced SCL falling edge.
REQ-020 FSM states: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-021 A START from any state SHALL go to ID and clear the bit counter; a repeated START SHALL keep REG_ADDR.
REQ-022 A STOP from any state SHALL go to IDLE, set SDA_OE=0 and BUSY=0.
REQ-023 In ID, after 8 bits: if the top 7 bits equal DEV_ID, go to ID_ACK; otherwise go to IGNORE and never drive SDA.
REQ-024 In ACK states, SDA_OE SHALL be 1 from the falling edge after bit 8 until the next falling edge.
REQ-025 After ID_ACK: if R/W=0, go to SUB; if R/W=1, go to RDATA.
REQ-026 After SUB_ACK, the received byte SHALL be latched into REG_ADDR, then go to WDATA.
REQ-027 On the 8th WDATA bit: write reg[REG_ADDR], update REG_WDATA, pulse REG_WE, then go to WDATA_ACK.
REQ-028 After WDATA_ACK: REG_ADDR SHALL increment by 1 (modulo 256, 0xFF->0x00), then go to WDATA.
REQ-029 Writes to 0x0A or 0x0B SHALL be ACKed but SHALL NOT modify the register and SHALL NOT pulse REG_WE.
REQ-030 In RDATA, SDA_OE SHALL equal the inverse of the current bit of reg[REG_ADDR], MSB first, starting at the falling edge after the ACK.
REQ-031 During RDATA_ACK, SDA SHALL be released and the initiator's bit sampled.
REQ-032 On initiator ACK (0): increment REG_ADDR (wraps) and continue in RDATA.
REQ-033 On initiator NACK (1): go to IGNORE until STOP or START.
REQ-034 A START and a data-bit sample SHALL never coincide; if a START and an SCL edge are detected in the same CLK, START wins.
REQ-035 The register file SHALL be 256x8; reads of 0x0A and 0x0B SHALL return PID_VAL and VER_VAL.

Reset
REQ-036 On RST, the FSM SHALL go to IDLE, with SDA_OE=0, REG_WE=0, BUSY=0, REG_ADDR=0x00, REG_WDATA=0x00, and the synchronizers set to 1.
REQ-037 On RST, every register-file location SHALL clear to 0x00, except that 0x0A and 0x0B hold PID_VAL and VER_VAL.
REQ-038 RST mid-transaction SHALL release SDA within 1 CLK; the bus SHALL then be ignored until the next START.

Structure
REQ-039 Package sccb_pkg SHALL hold the FSM state enum, the default DEV_ID, the PID/VER sub-address constants (0x0A, 0x0B), and the read/write ID-byte constants (0x42, 0x43).
REQ-040 One sub-module, sccb_line_sync, SHALL provide the 2-FF synchronizers plus START, STOP, SCL-rise and SCL-fall pulse outputs.

Verification
REQ-041 3-phase write of 0x42, 0x12, 0x80 -> three ACKs, one REG_WE pulse with REG_ADDR=0x12 and REG_WDATA=0x80, and DBG_DATA@0x12=0x80.
REQ-042 2-phase write 0x42, 0x0A, then STOP, START, 0x43 with a NACKed read -> SDA carries 0x76 and BUSY is low after STOP.
REQ-043 Write 0x42, 0xFF, 0x11, 0x22 -> 0x11 lands at 0xFF and 0x22 at 0x00 (wrap), with 2 REG_WE pulses.
REQ-044 ID byte 0x60 then 3 bytes -> SDA_OE stays 0 throughout, with no REG_WE and BUSY=0.
REQ-045 Write 0x42, 0x0B, 0x55 -> ACKed, no REG_WE, and a following read returns 0x73.
REQ-046 RST asserted during the 4th bit of the read data -> SDA_OE=0 next CLK; a subsequent valid write succeeds normally.
